branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch target buffer (BTB) with saturating-counter direction prediction for the pipelined RV32 core. In IF it predicts the next fetch PC from the current PC. In MEM, where branches and jumps resolve, it updates its table, detects mispredictions, and drives the redirect PC and the flush request. It replaces the fixed "predict not-taken, flush on any taken branch/jal" policy.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256
- XLEN, 32, address/data width
- CTR_BITS, 2, width of each direction counter; 1..4

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- if_pc  in  XLEN  PC being fetched
- pred_hit  out  1  if_pc matches a valid entry
- pred_taken  out  1  prediction is taken
- pred_next_pc  out  XLEN  predicted next fetch PC
- upd_valid  in  1  a control-flow instruction resolves in MEM this cycle
- upd_kind  in  2  0 = cond branch, 1 = jal, 2 = jalr, 3 = reserved (treated as no update)
- upd_pc  in  XLEN  PC of the resolving instruction
- upd_taken  in  1  actual direction (always 1 for jal/jalr)
- upd_target  in  XLEN  actual taken target
- upd_pred_next_pc  in  XLEN  pred_next_pc carried down the pipeline with the instruction
- bp_flush  in  1  invalidate all entries (fence.i)
- redirect  out  1  misprediction; the pipeline flushes IF/ID, ID/EX and EX/MEM
- redirect_pc  out  XLEN  correct next PC

## Operation
- Index = pc[IDX+1:2], where IDX = log2(ENTRIES). Tag = pc[XLEN-1:IDX+2]. Each entry holds: valid, tag, target, ctr, is_jal.
- Lookup is combinational from registered state:
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (is_jal || ctr MSB).
  - pred_next_pc = pred_taken ? target : if_pc + 4. Arithmetic wraps modulo 2^XLEN.
- Resolution is combinational:
  - actual = upd_taken ? upd_target : upd_pc + 4.
  - redirect = upd_valid && (actual != upd_pred_next_pc).
  - redirect_pc = actual.
  - jalr is never allocated, so a jalr always redirects unless fall-through happens to be correct.
- Table update on the clock edge when upd_valid and upd_kind is 0 or 1:
  - Hit, cond branch: ctr saturating +1 if taken, -1 if not taken; it never wraps past 0 or 2^CTR_BITS-1. Target is overwritten only when taken.
  - Hit, jal: target rewritten; is_jal = 1.
  - Miss, taken: allocate/replace the indexed entry (direct-mapped). Write valid = 1, tag, target, is_jal = (kind == 1), and ctr = weakly-taken (MSB set, rest 0).
  - Miss, not taken: no change.
- bp_flush clears every valid bit on the next edge. If bp_flush and an update occur in the same cycle, the flush wins and the update is dropped.

## Timing
- Lookup and redirect are zero-latency combinational paths. An update becomes visible to lookup on the cycle after its edge.
- If a lookup and an update hit the same index in the same cycle, the lookup sees the old contents.
- Reset (asynchronous assert, synchronous deassert by the core reset logic) clears all valid bits, all counters to 0, and all targets to 0.
- After reset: pred_hit = 0, pred_taken = 0, pred_next_pc = if_pc + 4, and redirect = 0 whenever upd_valid = 0.
- Reset mid-operation aborts any pending update; no partial entry write survives.

## Configuration
- BRANCH_PREDICTOR_STATS_EN defined adds three XLEN-wide counters, read on outputs stat_lookups, stat_updates and stat_mispredicts:
  - stat_lookups increments each cycle pred_hit = 1.
  - stat_updates increments on each upd_valid.
  - stat_mispredicts increments on each redirect.
  - All three saturate at all-ones, reset to 0, and are unaffected by bp_flush.
- Without the macro these ports and registers do not exist.

## Structure
- A shared package bp_pkg holds:
  - upd_kind encoding constants (KIND_BR, KIND_JAL, KIND_JALR)
  - the BTB entry typedef
  - the weakly-taken counter init function of CTR_BITS
- One sub-module, bp_sat_counter: a parametrised saturating up/down counter, instantiated once per entry.

## Test plan
- Reset, then if_pc = 0x100 -> pred_hit = 0, pred_next_pc = 0x104. Update with kind = 0, taken = 0, upd_pred_next_pc = 0x104 -> redirect = 0 and no allocation.
- Cond branch at 0x100, taken, target 0x40, upd_pred_next_pc = 0x104 -> redirect = 1, redirect_pc = 0x40. Next cycle, if_pc = 0x100 -> pred_taken = 1, pred_next_pc = 0x40.
- Same branch not taken twice (CTR_BITS = 2) -> ctr goes 2→1→0 and pred_taken = 0. Further not-taken updates keep ctr = 0; 5 taken updates saturate ctr at 3.
- jal at 0x200, target 0x800 -> allocated with is_jal. Then an aliasing PC 0x200 + 4·ENTRIES, taken to 0x900, replaces it -> lookup of 0x200 gives pred_hit = 0.
- jalr at 0x300 to 0x1000 with upd_pred_next_pc = 0x304 -> redirect = 1, redirect_pc = 0x1000, no entry allocated.
- Populated table: assert bp_flush together with a taken update -> every lookup misses next cycle. With BRANCH_PREDICTOR_STATS_EN, counters equal the number of hits, updates and redirects driven.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: update-kind encoding,
// per-entry control flags and the weakly-taken counter initialiser.
package bp_pkg;

    // Encoding of upd_kind; the fourth code is reserved and never updates the table.
    localparam logic [1:0] KIND_BR   = 2'd0;
    localparam logic [1:0] KIND_JAL  = 2'd1;
    localparam logic [1:0] KIND_JALR = 2'd2;

    // BTB entry control part. Tag and target widths depend on the top-level
    // parameters, so they live in parallel arrays beside this struct.
    // The direction counter lives in its own bp_sat_counter instance.
    typedef struct packed {
        logic valid;
        logic is_jal;
    } bp_entry_t;

    // Weakly-taken counter value: MSB set, all other bits clear.
    function automatic int weak_taken_init(input int ctr_bits);
        return 32'sd1 << (ctr_bits - 32'sd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter holding one BTB entry's direction state.
// A load has priority over counting; counting stops at 0 and at all-ones.
module bp_sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] cnt_r;

    // Counter state: load on allocation, otherwise saturating step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (inc && (cnt_r != {WIDTH{1'b1}})) begin
            cnt_r <= cnt_r + WIDTH'(1'b1);
        end else if (dec && (cnt_r != {WIDTH{1'b0}})) begin
            cnt_r <= cnt_r - WIDTH'(1'b1);
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Predicts the next fetch PC in IF and resolves/updates in MEM.
// Optional: define BRANCH_PREDICTOR_STATS_EN for lookup/update/mispredict
// statistics counters on stat_* outputs.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int XLEN     = 32,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [1:0]      upd_kind,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic [XLEN-1:0] upd_pred_next_pc,
    input  logic            bp_flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [XLEN-1:0] stat_lookups,
    output logic [XLEN-1:0] stat_updates,
    output logic [XLEN-1:0] stat_mispredicts
`endif
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_taken_init(CTR_BITS));

    bp_entry_t           meta_r   [ENTRIES];
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [XLEN-1:0]     target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_s    [ENTRIES];

    logic [IDX-1:0]   lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic [IDX-1:0]   up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    logic [XLEN-1:0]  actual_s;
    logic             kind_ok_s;
    logic             up_hit_s;
    logic             up_en_s;
    logic             alloc_s;
    logic             br_hit_s;
    logic             jal_hit_s;

    assign lk_idx_s = if_pc[IDX+1:2];
    assign lk_tag_s = if_pc[XLEN-1:IDX+2];
    assign up_idx_s = upd_pc[IDX+1:2];
    assign up_tag_s = upd_pc[XLEN-1:IDX+2];

    // Fetch-side lookup from registered table contents.
    always_comb begin
        pred_hit   = meta_r[lk_idx_s].valid && (tag_r[lk_idx_s] == lk_tag_s);
        pred_taken = pred_hit && (meta_r[lk_idx_s].is_jal || ctr_s[lk_idx_s][CTR_BITS-1]);
        if (pred_taken) begin
            pred_next_pc = target_r[lk_idx_s];
        end else begin
            pred_next_pc = if_pc + XLEN'(32'd4);
        end
    end

    // Resolution: compare the real next PC with what fetch assumed.
    always_comb begin
        if (upd_taken) begin
            actual_s = upd_target;
        end else begin
            actual_s = upd_pc + XLEN'(32'd4);
        end
        redirect    = upd_valid && (actual_s != upd_pred_next_pc);
        redirect_pc = actual_s;
    end

    // Update decode: only branches and jal train the table; flush drops the update.
    always_comb begin
        kind_ok_s = 1'b0;
        case (upd_kind)
            KIND_BR, KIND_JAL: kind_ok_s = 1'b1;
            KIND_JALR:         kind_ok_s = 1'b0;
            default:           kind_ok_s = 1'b0;
        endcase
        up_hit_s  = meta_r[up_idx_s].valid && (tag_r[up_idx_s] == up_tag_s);
        up_en_s   = upd_valid && kind_ok_s && !bp_flush;
        alloc_s   = up_en_s && !up_hit_s && upd_taken;
        br_hit_s  = up_en_s && up_hit_s && (upd_kind == KIND_BR);
        jal_hit_s = up_en_s && up_hit_s && (upd_kind == KIND_JAL);
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel_s;
        assign sel_s = (up_idx_s == IDX'(g));
        bp_sat_counter #(.WIDTH(CTR_BITS)) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .load     (sel_s && alloc_s),
            .load_val (CTR_INIT),
            .inc      (sel_s && br_hit_s && upd_taken),
            .dec      (sel_s && br_hit_s && !upd_taken),
            .value    (ctr_s[g])
        );
    end

    // Table write: flush beats update; allocate on taken miss, retarget on hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_r[i]   <= '0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
            end
        end else if (bp_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_r[i].valid <= 1'b0;
            end
        end else if (alloc_s) begin
            meta_r[up_idx_s]   <= '{valid: 1'b1, is_jal: (upd_kind == KIND_JAL)};
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= upd_target;
        end else if (jal_hit_s) begin
            meta_r[up_idx_s].is_jal <= 1'b1;
            target_r[up_idx_s]      <= upd_target;
        end else if (br_hit_s && upd_taken) begin
            target_r[up_idx_s] <= upd_target;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [XLEN-1:0] stat_lookups_r;
    logic [XLEN-1:0] stat_updates_r;
    logic [XLEN-1:0] stat_mispredicts_r;

    // Saturating event counters; unaffected by bp_flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups_r     <= '0;
            stat_updates_r     <= '0;
            stat_mispredicts_r <= '0;
        end else begin
            if (pred_hit && (stat_lookups_r != {XLEN{1'b1}})) begin
                stat_lookups_r <= stat_lookups_r + XLEN'(32'd1);
            end
            if (upd_valid && (stat_updates_r != {XLEN{1'b1}})) begin
                stat_updates_r <= stat_updates_r + XLEN'(32'd1);
            end
            if (redirect && (stat_mispredicts_r != {XLEN{1'b1}})) begin
                stat_mispredicts_r <= stat_mispredicts_r + XLEN'(32'd1);
            end
        end
    end

    assign stat_lookups     = stat_lookups_r;
    assign stat_updates     = stat_updates_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule
